decoder_stream: RTL and testbench
=================================

// Module: decoder_stream
// PURPOSE
// - Inverse of the team's 8-to-3 priority encoder: takes a (valid,index) code and regenerates the one-hot bus.
// - Streams codes over valid/ready handshakes, buffered by a 2-entry output FIFO (skid buffer), so upstream
//   encoder logic and the downstream consumer are decoupled.
// - Keeps saturating counters of decoded codes and error codes for debug.
// PARAMETERS
// - N_OUT  8  width of the one-hot output; 2..256
// - IDX_W  3  index width = $clog2(N_OUT); input code width is IDX_W+1
// - CNT_W  8  width of the saturating statistics counters
// PORTS
// - clk        in   1        rising-edge clock
// - rst_n      in   1        asynchronous active-low reset
// - in_valid   in   1        upstream presents in_code
// - in_ready   out  1        block can accept; a code transfers when in_valid & in_ready at posedge
// - in_code    in   IDX_W+1  [IDX_W]=any-bit-set flag from encoder, [IDX_W-1:0]=index
// - out_valid  out  1        head FIFO entry valid
// - out_ready  in   1        downstream accepts; pop when out_valid & out_ready at posedge
// - out_d      out  N_OUT    one-hot decode of head entry (all-zero for an error entry)
// - out_err    out  1        head entry was an error code
// - cnt_clr    in   1        synchronous clear of both counters
// - dec_cnt    out  CNT_W    count of accepted good codes
// - err_cnt    out  CNT_W    count of accepted error codes
// BEHAVIOUR
// - Reset (async, rst_n=0): FIFO empty; out_valid=0, out_d=0, out_err=0, in_ready=1, dec_cnt=0, err_cnt=0.
//   Reset mid-transfer discards all buffered entries; nothing is replayed after release.
// - Decode at accept: good if in_code[IDX_W]=1 and index<N_OUT -> entry {d=1<<index, err=0};
//   otherwise error -> entry {d=0, err=1}. Flag=0 is an error regardless of the index bits.
// - Latency: an accepted code appears on out_* on the next cycle when the FIFO was empty (1-cycle latency).
// - FIFO: 2 entries, registered head driving out_d/out_err directly (no combinational in->out path).
//   - States EMPTY(0) / ONE(1) / FULL(2); in_ready = (state!=FULL), registered, not dependent on out_ready.
//   - EMPTY: push -> ONE. ONE: push only -> FULL; pop only -> EMPTY; push+pop same cycle -> stays ONE and
//     the new entry becomes head. FULL: pop -> ONE (second entry promoted); push impossible (in_ready=0).
//   - Order preserved, no drops, no duplicates; out_d/out_err are held stable while out_valid & !out_ready.
//   - When out_valid=0, out_d=0 and out_err=0.
// - Counters: increment by 1 on each accepted code (dec_cnt for good, err_cnt for error); saturate at
//   2^CNT_W-1 (no wrap). cnt_clr=1 forces both counters to 0 that cycle and has priority over a same-cycle
//   increment. Counters are unaffected by pops or out_ready.
// - in_code is ignored when in_valid=0 or in_ready=0; X on in_code is permitted in that case.
// TESTING
// - Reset, then codes 4'b1000..4'b1111 back-to-back with out_ready=1 -> out_d 0x01,0x02,..,0x80, each one
//   cycle after accept; out_err=0; dec_cnt=8.
// - Error: in_code=4'b0101 -> out_d=0x00, out_err=1, err_cnt=1, dec_cnt unchanged.
// - Backpressure: out_ready=0, push 3 codes -> first 2 accepted, in_ready=0 on the 3rd; out_d held at first
//   entry; release out_ready -> entries drain in order, third code then accepted.
// - Simultaneous push+pop in ONE state for 20 cycles -> in_ready stays 1, 1-cycle throughput, no loss.
// - Saturation (CNT_W=3): 9 good codes -> dec_cnt=7; cnt_clr pulsed with a same-cycle accept -> dec_cnt=0.
// - rst_n asserted with FIFO FULL -> out_valid=0, out_d=0, in_ready=1 immediately (async), counters 0.

Source files
------------

// File: rtl/decoder_stream.sv
// Streaming one-hot decoder: (flag,index) codes in, one-hot words out through a
// 2-entry registered FIFO, with saturating counts of good and error codes.
module decoder_stream #(
    parameter int N_OUT = 8,
    parameter int IDX_W = $clog2(N_OUT),
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IDX_W:0]   in_code,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N_OUT-1:0] out_d,
    output logic             out_err,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] dec_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    localparam logic [IDX_W:0] IDX_LIMIT = (IDX_W + 1)'(N_OUT);

    state_t             state_q, state_d;
    logic [N_OUT-1:0]   head_d_q, head_d_d;
    logic               head_err_q, head_err_d;
    logic [N_OUT-1:0]   tail_d_q, tail_d_d;
    logic               tail_err_q, tail_err_d;
    logic [CNT_W-1:0]   dec_cnt_q, dec_cnt_d;
    logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;

    logic               push, pop, code_good;
    logic [N_OUT-1:0]   new_d;

    assign in_ready  = (state_q != FULL);
    assign out_valid = (state_q != EMPTY);
    assign out_d     = head_d_q;
    assign out_err   = head_err_q;
    assign dec_cnt   = dec_cnt_q;
    assign err_cnt   = err_cnt_q;

    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    // An index beyond N_OUT is only reachable when N_OUT is not a power of two.
    assign code_good = in_code[IDX_W] && ({1'b0, in_code[IDX_W-1:0]} < IDX_LIMIT);
    assign new_d     = code_good ? ({{(N_OUT-1){1'b0}}, 1'b1} << in_code[IDX_W-1:0]) : '0;

    always_comb begin
        state_d    = state_q;
        head_d_d   = head_d_q;
        head_err_d = head_err_q;
        tail_d_d   = tail_d_q;
        tail_err_d = tail_err_q;
        unique case (state_q)
            EMPTY: begin
                if (push) begin
                    head_d_d   = new_d;
                    head_err_d = !code_good;
                    state_d    = ONE;
                end
            end
            ONE: begin
                if (push && pop) begin
                    head_d_d   = new_d;
                    head_err_d = !code_good;
                end else if (push) begin
                    tail_d_d   = new_d;
                    tail_err_d = !code_good;
                    state_d    = FULL;
                end else if (pop) begin
                    // Clearing the head keeps out_d/out_err at zero while empty.
                    head_d_d   = '0;
                    head_err_d = 1'b0;
                    state_d    = EMPTY;
                end
            end
            FULL: begin
                if (pop) begin
                    head_d_d   = tail_d_q;
                    head_err_d = tail_err_q;
                    tail_d_d   = '0;
                    tail_err_d = 1'b0;
                    state_d    = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_comb begin
        dec_cnt_d = dec_cnt_q;
        err_cnt_d = err_cnt_q;
        if (cnt_clr) begin
            dec_cnt_d = '0;
            err_cnt_d = '0;
        end else if (push) begin
            if (code_good && dec_cnt_q != '1) dec_cnt_d = dec_cnt_q + 1'b1;
            if (!code_good && err_cnt_q != '1) err_cnt_d = err_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= EMPTY;
            head_d_q   <= '0;
            head_err_q <= 1'b0;
            tail_d_q   <= '0;
            tail_err_q <= 1'b0;
            dec_cnt_q  <= '0;
            err_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            head_d_q   <= head_d_d;
            head_err_q <= head_err_d;
            tail_d_q   <= tail_d_d;
            tail_err_q <= tail_err_d;
            dec_cnt_q  <= dec_cnt_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

endmodule

// File: tb/tb_decoder_stream.sv
// Bench for decoder_stream: scoreboard queue fed at accept, checked at the head each cycle.
module tb_decoder_stream;

    localparam int N_OUT = 8;
    localparam int IDX_W = 3;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid, in_ready;
    logic [IDX_W:0]   in_code;
    logic             out_valid, out_ready;
    logic [N_OUT-1:0] out_d;
    logic             out_err;
    logic             cnt_clr;
    logic [CNT_W-1:0] dec_cnt, err_cnt;

    logic             s_in_valid, s_in_ready, s_out_valid, s_out_err, s_cnt_clr;
    logic [IDX_W:0]   s_in_code;
    logic [N_OUT-1:0] s_out_d;
    logic [2:0]       s_dec_cnt, s_err_cnt;

    always #5 clk = ~clk;

    decoder_stream #(.N_OUT(N_OUT), .IDX_W(IDX_W), .CNT_W(CNT_W)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_code(in_code),
        .out_valid(out_valid), .out_ready(out_ready), .out_d(out_d), .out_err(out_err),
        .cnt_clr(cnt_clr), .dec_cnt(dec_cnt), .err_cnt(err_cnt)
    );

    decoder_stream #(.N_OUT(N_OUT), .IDX_W(IDX_W), .CNT_W(3)) u_sat (
        .clk(clk), .rst_n(rst_n),
        .in_valid(s_in_valid), .in_ready(s_in_ready), .in_code(s_in_code),
        .out_valid(s_out_valid), .out_ready(1'b1), .out_d(s_out_d), .out_err(s_out_err),
        .cnt_clr(s_cnt_clr), .dec_cnt(s_dec_cnt), .err_cnt(s_err_cnt)
    );

    typedef struct packed {
        logic [N_OUT-1:0] d;
        logic             err;
    } exp_t;

    exp_t q[$];
    exp_t head_e, new_e;
    int   vectors = 0;
    int   miscompares = 0;
    int   m_dec = 0;
    int   m_err = 0;
    int   cyc = 0;
    bit   m_acc, m_pop;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic [IDX_W:0] c);
        exp_t e;
        logic [N_OUT-1:0] one;
        one = 1;
        if (c[IDX_W]) begin
            e.d   = one << c[IDX_W-1:0];
            e.err = 1'b0;
        end else begin
            e.d   = '0;
            e.err = 1'b1;
        end
        return e;
    endfunction

    // Scoreboard monitor: compare against the model, then apply this cycle's transfers.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                q.delete();
                m_dec = 0;
                m_err = 0;
            end
            head_e = (q.size() > 0) ? q[0] : '0;
            check_eq("in_ready", in_ready, q.size() < 2);
            check_eq("out_valid", out_valid, q.size() > 0);
            check_eq("out_d", out_d, head_e.d);
            check_eq("out_err", out_err, head_e.err);
            check_eq("dec_cnt", dec_cnt, m_dec);
            check_eq("err_cnt", err_cnt, m_err);
            if (rst_n) begin
                m_acc = in_valid && (q.size() < 2);
                m_pop = (q.size() > 0) && out_ready;
                if (m_acc) new_e = model(in_code);
                if (cnt_clr) begin
                    m_dec = 0;
                    m_err = 0;
                end else if (m_acc) begin
                    if (!new_e.err && m_dec < 255) m_dec++;
                    if (new_e.err && m_err < 255) m_err++;
                end
                if (m_pop) void'(q.pop_front());
                if (m_acc) q.push_back(new_e);
            end
        end
    end

    task automatic send(input logic [IDX_W:0] code);
        bit acc;
        int n;
        n = 0;
        in_valid = 1'b1;
        in_code  = code;
        do begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!acc && n < 50);
        check_eq("accept_timeout", acc, 1'b1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() > 0 && n < 50) begin
            @(posedge clk);
            n++;
        end
        #1;
        check_eq("drain", q.size(), 0);
    endtask

    initial begin
        int t0;
        rst_n = 1'b1;
        in_valid = 1'b0; in_code = '0; out_ready = 1'b0; cnt_clr = 1'b0;
        s_in_valid = 1'b0; s_in_code = '0; s_cnt_clr = 1'b0;
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) send(4'(8 + i));
        drain();
        check_eq("dec_after_8", dec_cnt, 8);

        send(4'b0101);
        drain();
        check_eq("err_after_bad", err_cnt, 1);
        check_eq("dec_after_bad", dec_cnt, 8);

        out_ready = 1'b0;
        send(4'b1010);
        send(4'b1011);
        in_valid = 1'b1;
        in_code  = 4'b1100;
        repeat (3) @(posedge clk);
        #1;
        check_eq("bp_in_ready", in_ready, 0);
        check_eq("bp_head_held", out_d, 8'h04);
        out_ready = 1'b1;
        send(4'b1100);
        drain();

        t0 = cyc;
        for (int i = 0; i < 20; i++) send(4'($urandom_range(15)));
        check_eq("throughput_cycles", cyc - t0, 20);
        drain();

        cnt_clr = 1'b1;
        send(4'b1001);
        cnt_clr = 1'b0;
        drain();
        check_eq("clr_dec", dec_cnt, 0);

        out_ready = 1'b0;
        send(4'b1110);
        send(4'b1111);
        #1 rst_n = 1'b0;
        #1;
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_out_d", out_d, 0);
        check_eq("rst_in_ready", in_ready, 1);
        check_eq("rst_dec_cnt", dec_cnt, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        send(4'b1011);
        drain();

        s_in_valid = 1'b1;
        s_in_code  = 4'b1000;
        repeat (9) @(posedge clk);
        #1;
        check_eq("sat_dec", s_dec_cnt, 7);
        s_cnt_clr = 1'b1;
        @(posedge clk);
        #1;
        s_cnt_clr  = 1'b0;
        s_in_valid = 1'b0;
        check_eq("sat_clr_dec", s_dec_cnt, 0);
        check_eq("sat_clr_err", s_err_cnt, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
